carry_skip_adder_pipe: RTL
==========================

Name: carry_skip_adder_pipe

Overview:
- Parametrised, pipelined carry-skip (carry-bypass) adder/subtractor for the datapath ALU.
- The operand width is split into BLOCK-bit ripple blocks. Each block carries a propagate-driven bypass mux.
- Blocks are grouped into pipeline segments separated by registers.
- Valid/ready handshake on both sides; full-rate throughput with backpressure stall; signed-overflow, zero and skip-count status per result.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK*SEG.
- BLOCK, 4, bits per ripple block (bypass granularity).
- SEG, 2, ripple blocks per pipeline segment; NSEG = WIDTH/(BLOCK*SEG) = pipeline depth (default 4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A (two's complement).
- b  in  WIDTH  operand B (two's complement).
- cin  in  1  carry-in (add mode only).
- sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (in sub mode: 1 = no borrow).
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.
- skip_cnt  out  $clog2(WIDTH/BLOCK)+1  number of blocks whose carry was taken via bypass for this result.

Behaviour:
- Reset (rst high at posedge): all stage valid bits, out_valid, sum, cout, overflow, zero and skip_cnt clear to 0. in_ready = 1 in the cycle after reset. Any in-flight beats are discarded with no output.
- Operand conditioning at input:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - a, b_eff, c0, sign bits a[W-1] and b_eff[W-1], and the sub flag are registered into stage 0 on accept.
- Stage k (0..NSEG-1):
  - Computes SEG ripple blocks for bits [k*BLOCK*SEG +: BLOCK*SEG] using the carry registered from stage k-1 (c0 for k=0).
  - Per block j, P_j = AND of (a_i ^ b_eff_i) over the block.
  - Block carry-out = P_j ? block carry-in : ripple carry-out.
  - skip_cnt accumulates +1 per block with P_j = 1.
  - Lower sum bits already computed and the untouched upper operand bits travel with the beat.
- Latency: a beat accepted at posedge N has out_valid = 1 from posedge N+NSEG.
- Outputs are registered in the final stage:
  - cout = carry out of the top block.
  - overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
  - zero = ~|sum.
- Handshake:
  - Accept when in_valid && in_ready.
  - Result transfers when out_valid && out_ready.
  - stall = out_valid && !out_ready; all stages hold when stall = 1; in_ready = !stall (combinational).
  - Bubbles are not compressed: the pipeline advances as a whole. out_valid may drop between beats if the input had gaps.
- Outputs must not change while out_valid && !out_ready.
- Simultaneous accept and output transfer in the same cycle are both legal when out_ready = 1; throughput is 1 beat/cycle.
- Ordering is strict FIFO; no reordering.
- in_valid while in_ready = 0: the beat is not taken; the upstream must hold it (AXI-stream rule).
- Wrap-around: 0xFFFFFFFF + 1 gives sum = 0, cout = 1, zero = 1, overflow = 0.

Test Plan:
- Basic add, full propagate:
  - Stimulus: reset 2 cycles; then one beat a = 0x0000_00FF, b = 0x0000_0001, cin = 0, sub = 0; out_ready = 1.
  - Response: exactly 4 cycles later sum = 0x0000_0100, cout = 0, overflow = 0, zero = 0.
- Full bypass chain:
  - Stimulus: a = 0xFFFF_FFFF, b = 0x0000_0000, cin = 1.
  - Response: sum = 0, cout = 1, zero = 1, skip_cnt = 8.
- Subtract and signed overflow:
  - Stimulus: a = 0x8000_0000, b = 0x0000_0001, sub = 1.
  - Response: sum = 0x7FFF_FFFF, overflow = 1, cout = 1.
  - Stimulus: a = 5, b = 7, sub = 1.
  - Response: sum = 0xFFFF_FFFE, cout = 0, overflow = 0.
- Back-to-back stream with backpressure:
  - Stimulus: 16 random beats, in_valid held high; out_ready low for cycles 6-9.
  - Response: in_ready low exactly while out_valid && !out_ready; outputs are stable during the stall; all 16 results match the reference model in order with none lost or duplicated.
- Reset mid-flight:
  - Stimulus: 3 beats in the pipe; assert rst for 1 cycle.
  - Response: out_valid = 0 and all status outputs = 0 next cycle; no stale result appears afterwards.
- Parameter sweep:
  - Configurations: WIDTH = 16, BLOCK = 2, SEG = 2 (latency 4); WIDTH = 64, BLOCK = 8, SEG = 1 (latency 8).
  - Response: 1000 random beats per configuration compared against a behavioural +/- model.

Source files
------------

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor.
// The operand is split into BLOCK-bit ripple blocks; each block bypasses its
// ripple carry when every bit propagates. SEG blocks form one pipeline
// segment. An input register level precedes the NSEG segments, so a beat
// accepted at posedge N is presented at the outputs from posedge N+NSEG.
// The whole pipeline advances together and freezes while the consumer
// stalls a valid result.
module carry_skip_adder_pipe #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4,
   parameter int SEG   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic                         cin,
   input  logic                         sub,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             sum,
   output logic                         cout,
   output logic                         overflow,
   output logic                         zero,
   output logic [$clog2(WIDTH/BLOCK):0] skip_cnt
);

   localparam int SW   = BLOCK * SEG;
   localparam int NSEG = WIDTH / SW;
   localparam int CW   = $clog2(WIDTH / BLOCK) + 1;

   // Level k feeds segment k: operands, incoming carry, partial sum, skips.
   logic             v_q [NSEG];
   logic [WIDTH-1:0] a_q [NSEG];
   logic [WIDTH-1:0] b_q [NSEG];
   logic             c_q [NSEG];
   logic [WIDTH-1:0] s_q [NSEG];
   logic [CW-1:0]    n_q [NSEG];

   // Segment results, i.e. the next state of level k+1 (or of the outputs).
   logic [WIDTH-1:0] s_d [NSEG];
   logic             c_d [NSEG];
   logic [CW-1:0]    n_d [NSEG];

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             overflow_q;
   logic             zero_q;
   logic [CW-1:0]    skip_q;

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall;
   assign b_eff    = sub ? ~b : b;
   assign c0       = sub | cin;

   // Ripple each block of every segment, taking the bypass when the block propagates.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         logic carry;
         logic cb;
         logic rc;
         logic p;
         logic x;
         logic [CW-1:0] cnt;
         int idx;
         s_d[k] = s_q[k];
         carry  = c_q[k];
         cnt    = n_q[k];
         for (int j = 0; j < SEG; j++) begin
            cb = carry;
            rc = cb;
            p  = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
               idx          = k * SW + j * BLOCK + i;
               x            = a_q[k][idx] ^ b_q[k][idx];
               s_d[k][idx]  = x ^ rc;
               rc           = (a_q[k][idx] & b_q[k][idx]) | (x & rc);
               p            = p & x;
            end
            carry = p ? cb : rc;
            cnt   = cnt + CW'(p);
         end
         c_d[k] = carry;
         n_d[k] = cnt;
      end
   end

   // Advance the whole pipeline unless the output is stalled; data only moves with valid beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            c_q[k] <= 1'b0;
            s_q[k] <= '0;
            n_q[k] <= '0;
         end
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         skip_q      <= '0;
      end else if (!stall) begin
         v_q[0] <= in_valid;
         if (in_valid) begin
            a_q[0] <= a;
            b_q[0] <= b_eff;
            c_q[0] <= c0;
            s_q[0] <= '0;
            n_q[0] <= '0;
         end
         for (int k = 1; k < NSEG; k++) begin
            v_q[k] <= v_q[k-1];
            if (v_q[k-1]) begin
               a_q[k] <= a_q[k-1];
               b_q[k] <= b_q[k-1];
               c_q[k] <= c_d[k-1];
               s_q[k] <= s_d[k-1];
               n_q[k] <= n_d[k-1];
            end
         end
         out_valid_q <= v_q[NSEG-1];
         if (v_q[NSEG-1]) begin
            sum_q      <= s_d[NSEG-1];
            cout_q     <= c_d[NSEG-1];
            overflow_q <= (a_q[NSEG-1][WIDTH-1] == b_q[NSEG-1][WIDTH-1]) &&
                          (s_d[NSEG-1][WIDTH-1] != a_q[NSEG-1][WIDTH-1]);
            zero_q     <= ~|s_d[NSEG-1];
            skip_q     <= n_d[NSEG-1];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign skip_cnt  = skip_q;

endmodule
